// File: rtl/ex_operand_stage.sv
// Operand-delivery stage ahead of the ALU: MEM/WB forwarding,
// source select and a 2-entry skid buffer on a valid/ready handshake.
module ex_operand_stage #(
  parameter int DATA_W = 32,
  parameter int RA_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_alu_op,
  input  logic [DATA_W-1:0] in_rs1_data,
  input  logic [DATA_W-1:0] in_rs2_data,
  input  logic [RA_W-1:0]   in_rs1_addr,
  input  logic [RA_W-1:0]   in_rs2_addr,
  input  logic [RA_W-1:0]   in_rd_addr,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [DATA_W-1:0] in_imm,
  input  logic              in_src1_sel,
  input  logic              in_src2_sel,
  input  logic              fwd_mem_en,
  input  logic              fwd_wb_en,
  input  logic [RA_W-1:0]   fwd_mem_rd,
  input  logic [RA_W-1:0]   fwd_wb_rd,
  input  logic [DATA_W-1:0] fwd_mem_data,
  input  logic [DATA_W-1:0] fwd_wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_alu_op,
  output logic [DATA_W-1:0] out_in1,
  output logic [DATA_W-1:0] out_in2,
  output logic [DATA_W-1:0] out_store_data,
  output logic [RA_W-1:0]   out_rd_addr
);

  typedef struct packed {
    logic [3:0]        op;
    logic [DATA_W-1:0] in1;
    logic [DATA_W-1:0] in2;
    logic [DATA_W-1:0] sd;
    logic [RA_W-1:0]   rd;
  } beat_t;

  beat_t main_q, skid_q, nxt;
  logic  main_valid, skid_valid;
  logic  accept, take;
  logic  rs1_mem, rs1_wb, rs2_mem, rs2_wb;
  logic [DATA_W-1:0] fwd_rs1, fwd_rs2;

  // x0 never forwards; MEM wins over WB
  assign rs1_mem = (|in_rs1_addr) & fwd_mem_en
                 & (fwd_mem_rd == in_rs1_addr);
  assign rs1_wb  = (|in_rs1_addr) & fwd_wb_en
                 & (fwd_wb_rd == in_rs1_addr) & ~rs1_mem;
  assign rs2_mem = (|in_rs2_addr) & fwd_mem_en
                 & (fwd_mem_rd == in_rs2_addr);
  assign rs2_wb  = (|in_rs2_addr) & fwd_wb_en
                 & (fwd_wb_rd == in_rs2_addr) & ~rs2_mem;

  // resolve both sources and build the incoming payload
  always_comb begin
    fwd_rs1 = in_rs1_data;
    fwd_rs2 = in_rs2_data;
    unique case (1'b1)
      rs1_mem: fwd_rs1 = fwd_mem_data;
      rs1_wb:  fwd_rs1 = fwd_wb_data;
      default: fwd_rs1 = in_rs1_data;
    endcase
    unique case (1'b1)
      rs2_mem: fwd_rs2 = fwd_mem_data;
      rs2_wb:  fwd_rs2 = fwd_wb_data;
      default: fwd_rs2 = in_rs2_data;
    endcase
    nxt.op  = in_alu_op;
    nxt.in1 = in_src1_sel ? in_pc  : fwd_rs1;
    nxt.in2 = in_src2_sel ? in_imm : fwd_rs2;
    nxt.sd  = fwd_rs2;
    nxt.rd  = in_rd_addr;
  end

  assign in_ready = ~skid_valid;
  assign accept   = in_valid & in_ready;
  assign take     = main_valid & out_ready;

  // main/skid occupancy and payload capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (skid_valid) begin
      if (take) begin
        main_q     <= skid_q;
        skid_valid <= 1'b0;
      end
    end else if (!main_valid || take) begin
      main_valid <= accept;
      if (accept) main_q <= nxt;
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_q     <= nxt;
    end
  end

  assign out_valid      = main_valid;
  assign out_alu_op     = main_q.op;
  assign out_in1        = main_q.in1;
  assign out_in2        = main_q.in2;
  assign out_store_data = main_q.sd;
  assign out_rd_addr    = main_q.rd;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Bench for ex_operand_stage: directed table, hand sequences,
// and random traffic against a queue-based reference model.
module tb_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_alu_op;
  logic [31:0] in_rs1_data, in_rs2_data;
  logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
  logic [31:0] in_pc, in_imm;
  logic        in_src1_sel, in_src2_sel;
  logic        fwd_mem_en, fwd_wb_en;
  logic [4:0]  fwd_mem_rd, fwd_wb_rd;
  logic [31:0] fwd_mem_data, fwd_wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_alu_op;
  logic [31:0] out_in1, out_in2, out_store_data;
  logic [4:0]  out_rd_addr;

  ex_operand_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_op(in_alu_op),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
    .in_rd_addr(in_rd_addr), .in_pc(in_pc), .in_imm(in_imm),
    .in_src1_sel(in_src1_sel), .in_src2_sel(in_src2_sel),
    .fwd_mem_en(fwd_mem_en), .fwd_wb_en(fwd_wb_en),
    .fwd_mem_rd(fwd_mem_rd), .fwd_wb_rd(fwd_wb_rd),
    .fwd_mem_data(fwd_mem_data), .fwd_wb_data(fwd_wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_alu_op(out_alu_op), .out_in1(out_in1), .out_in2(out_in2),
    .out_store_data(out_store_data), .out_rd_addr(out_rd_addr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [31:0] sd;
    logic [4:0]  rd;
  } beat_t;

  typedef struct {
    logic [4:0]  a1, a2;
    logic [31:0] d1, d2;
    logic        me, we;
    logic [4:0]  mrd, wrd;
    logic [31:0] md, wd;
    logic        s1, s2;
    logic [31:0] pc, imm;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic [31:0] e1, e2, esd;
  } vec_t;

  beat_t mq[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] src(logic [4:0] a, logic [31:0] d);
    if (a == 5'd0) return d;
    if (fwd_mem_en && fwd_mem_rd == a) return fwd_mem_data;
    if (fwd_wb_en && fwd_wb_rd == a) return fwd_wb_data;
    return d;
  endfunction

  function automatic beat_t expect_beat();
    beat_t b;
    logic [31:0] r1, r2;
    r1 = src(in_rs1_addr, in_rs1_data);
    r2 = src(in_rs2_addr, in_rs2_data);
    b.op  = in_alu_op;
    b.in1 = in_src1_sel ? in_pc : r1;
    b.in2 = in_src2_sel ? in_imm : r2;
    b.sd  = r2;
    b.rd  = in_rd_addr;
    return b;
  endfunction

  // model: a FIFO of capacity 2; accepts only when it holds < 2
  task automatic model_edge();
    bit acc;
    acc = in_valid && (mq.size() < 2);
    if (flush) mq.delete();
    else begin
      if (mq.size() > 0 && out_ready) void'(mq.pop_front());
      if (acc) mq.push_back(expect_beat());
    end
  endtask

  task automatic check_model();
    chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
    chk("in_ready", 32'(in_ready), 32'(mq.size() < 2));
    if (mq.size() > 0) begin
      chk("alu_op", 32'(out_alu_op), 32'(mq[0].op));
      chk("in1", out_in1, mq[0].in1);
      chk("in2", out_in2, mq[0].in2);
      chk("store_data", out_store_data, mq[0].sd);
      chk("rd_addr", 32'(out_rd_addr), 32'(mq[0].rd));
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic check_reset_vals(string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_op"}, 32'(out_alu_op), 32'd0);
    chk({tag, "_in1"}, out_in1, 32'd0);
    chk({tag, "_in2"}, out_in2, 32'd0);
    chk({tag, "_sd"}, out_store_data, 32'd0);
    chk({tag, "_rd"}, 32'(out_rd_addr), 32'd0);
  endtask

  task automatic idle();
    flush = 0; in_valid = 0; in_alu_op = 0;
    in_rs1_data = 0; in_rs2_data = 0;
    in_rs1_addr = 0; in_rs2_addr = 0; in_rd_addr = 0;
    in_pc = 0; in_imm = 0; in_src1_sel = 0; in_src2_sel = 0;
    fwd_mem_en = 0; fwd_wb_en = 0; fwd_mem_rd = 0; fwd_wb_rd = 0;
    fwd_mem_data = 0; fwd_wb_data = 0;
  endtask

  task automatic plain(logic [3:0] op, logic [31:0] a, logic [31:0] b);
    in_valid = 1; in_alu_op = op;
    in_rs1_addr = 5'd1; in_rs2_addr = 5'd2;
    in_rs1_data = a; in_rs2_data = b; in_rd_addr = 5'(op);
    fwd_mem_en = 0; fwd_wb_en = 0;
    in_src1_sel = 0; in_src2_sel = 0;
  endtask

  vec_t tv[6];

  initial begin
    tv[0] = '{5'd1, 5'd2, 32'd5, 32'd7, 1'b0, 1'b0, 5'd0, 5'd0,
              32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0, 5'd9,
              32'd5, 32'd7, 32'd7};
    tv[1] = '{5'd3, 5'd4, 32'd9, 32'd8, 1'b1, 1'b1, 5'd3, 5'd3,
              32'hAAAA0000, 32'h1111, 1'b0, 1'b0, 32'd0, 32'd0,
              4'h1, 5'd10, 32'hAAAA0000, 32'd8, 32'd8};
    tv[2] = '{5'd3, 5'd4, 32'd9, 32'd8, 1'b0, 1'b1, 5'd3, 5'd3,
              32'hAAAA0000, 32'h1111, 1'b0, 1'b0, 32'd0, 32'd0,
              4'h2, 5'd11, 32'h1111, 32'd8, 32'd8};
    tv[3] = '{5'd0, 5'd0, 32'd0, 32'h22, 1'b1, 1'b1, 5'd0, 5'd0,
              32'hAAAA0000, 32'h1111, 1'b0, 1'b0, 32'd0, 32'd0,
              4'h3, 5'd12, 32'd0, 32'h22, 32'h22};
    tv[4] = '{5'd5, 5'd5, 32'd1, 32'h99, 1'b1, 1'b1, 5'd5, 5'd5,
              32'h55, 32'h66, 1'b1, 1'b1, 32'h100, 32'hFFFFFFFC,
              4'h4, 5'd13, 32'h100, 32'hFFFFFFFC, 32'h55};
    tv[5] = '{5'd6, 5'd7, 32'd1, 32'd2, 1'b1, 1'b1, 5'd6, 5'd7,
              32'hDEAD, 32'hBEEF, 1'b0, 1'b0, 32'd0, 32'd0,
              4'hF, 5'd31, 32'hDEAD, 32'hBEEF, 32'hBEEF};

    idle();
    out_ready = 1;
    rst_n = 0;
    #2;
    check_reset_vals("rst");
    #10 rst_n = 1;

    // directed forwarding / select table
    foreach (tv[i]) begin
      in_valid = 1;
      in_rs1_addr = tv[i].a1; in_rs2_addr = tv[i].a2;
      in_rs1_data = tv[i].d1; in_rs2_data = tv[i].d2;
      fwd_mem_en = tv[i].me; fwd_wb_en = tv[i].we;
      fwd_mem_rd = tv[i].mrd; fwd_wb_rd = tv[i].wrd;
      fwd_mem_data = tv[i].md; fwd_wb_data = tv[i].wd;
      in_src1_sel = tv[i].s1; in_src2_sel = tv[i].s2;
      in_pc = tv[i].pc; in_imm = tv[i].imm;
      in_alu_op = tv[i].op; in_rd_addr = tv[i].rd;
      cycle();
      chk("tv_valid", 32'(out_valid), 32'd1);
      chk("tv_in1", out_in1, tv[i].e1);
      chk("tv_in2", out_in2, tv[i].e2);
      chk("tv_sd", out_store_data, tv[i].esd);
      chk("tv_op", 32'(out_alu_op), 32'(tv[i].op));
      chk("tv_rd", 32'(out_rd_addr), 32'(tv[i].rd));
    end
    idle();
    cycle();

    // backpressure: A held, B in skid, C refused until drain
    out_ready = 0;
    plain(4'hA, 32'hA1, 32'hA2); cycle();
    plain(4'hB, 32'hB1, 32'hB2); cycle();
    chk("bp_ready_low", 32'(in_ready), 32'd0);
    plain(4'hC, 32'hC1, 32'hC2);
    cycle(); cycle();
    chk("bp_hold_a", out_in1, 32'hA1);
    chk("bp_hold_ready", 32'(in_ready), 32'd0);
    out_ready = 1;
    cycle();
    chk("bp_b_out", out_in1, 32'hB1);
    cycle();
    in_valid = 0;
    chk("bp_c_out", out_in1, 32'hC1);
    cycle();
    chk("bp_drained", 32'(out_valid), 32'd0);

    // flush with two buffered and a third presented
    out_ready = 0;
    plain(4'h1, 32'h11, 32'h12); cycle();
    plain(4'h2, 32'h21, 32'h22); cycle();
    plain(4'h3, 32'h31, 32'h32); flush = 1;
    cycle();
    chk("fl_valid", 32'(out_valid), 32'd0);
    chk("fl_ready", 32'(in_ready), 32'd1);
    idle(); out_ready = 1;
    repeat (3) begin
      cycle();
      chk("fl_nothing", 32'(out_valid), 32'd0);
    end

    // async reset mid-stream, then 1-cycle latency after release
    plain(4'h7, 32'h71, 32'h72); out_ready = 0;
    cycle(); cycle();
    #2 rst_n = 0;
    #1;
    mq.delete();
    check_reset_vals("arst");
    #1 rst_n = 1;
    plain(4'h9, 32'h91, 32'h92); out_ready = 1;
    cycle();
    chk("arst_first", out_in1, 32'h91);
    idle();
    cycle();

    // random traffic against the FIFO model
    for (int n = 0; n < 400; n++) begin
      in_valid     = $urandom_range(0, 3) != 0;
      out_ready    = $urandom_range(0, 2) != 0;
      flush        = $urandom_range(0, 24) == 0;
      in_alu_op    = 4'($urandom);
      in_rs1_addr  = 5'($urandom_range(0, 3));
      in_rs2_addr  = 5'($urandom_range(0, 3));
      in_rd_addr   = 5'($urandom);
      in_rs1_data  = $urandom;
      in_rs2_data  = $urandom;
      in_pc        = $urandom;
      in_imm       = $urandom;
      in_src1_sel  = 1'($urandom);
      in_src2_sel  = 1'($urandom);
      fwd_mem_en   = 1'($urandom);
      fwd_wb_en    = 1'($urandom);
      fwd_mem_rd   = 5'($urandom_range(0, 3));
      fwd_wb_rd    = 5'($urandom_range(0, 3));
      fwd_mem_data = $urandom;
      fwd_wb_data  = $urandom;
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
